// File: rtl/xor_share_arb.sv
// xor_share_arb: round-robin arbiter in front of a single bit-serial XOR unit.
// The winning requester's operands are captured on its grant and streamed
// LSB-first through one 1-bit cmosxor cell. The result appears W+1 cycles
// after the grant, together with the id of the served requester.
module xor_share_arb #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   res,
  output logic [1:0]     res_id
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q;
  logic [1:0]      ptr_q;
  logic [1:0]      win_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    a_sr_q;
  logic [W-1:0]    b_sr_q;
  logic [W-1:0]    res_sr_q;
  logic [N-1:0]    gnt_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    res_q;
  logic [1:0]      res_id_q;

  logic [1:0]      win_d;
  logic            found_d;
  logic [N-1:0]    gnt_d;
  logic [W-1:0]    res_sr_d;
  logic [W-1:0]    a_sel_s;
  logic [W-1:0]    b_sel_s;
  logic            f53_s;

  // The only XOR resource: one bit per SHIFT cycle, fed by the operand LSBs.
  cmosxor u_xor (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .f53 (f53_s)
  );

  // Round-robin pick: first requesting index at or after ptr, wrapping.
  always_comb begin
    logic [1:0] idx;
    logic       hit;
    win_d   = ptr_q;
    found_d = 1'b0;
    gnt_d   = '0;
    idx     = 2'd0;
    hit     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx     = ptr_q + 2'(k);
      hit     = req[idx] & ~found_d;
      win_d   = hit ? idx : win_d;
      found_d = found_d | req[idx];
    end
    gnt_d[win_d] = 1'b1;
  end

  // Operand lanes of the current winner, and the next result shift value.
  always_comb begin
    a_sel_s  = a_in[int'(win_q) * W +: W];
    b_sel_s  = b_in[int'(win_q) * W +: W];
    res_sr_d = {f53_s, res_sr_q[W-1:1]};
  end

  // Control FSM with registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      win_q    <= 2'd0;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      res_id_q <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          a_sr_q  <= a_sel_s;
          b_sr_q  <= b_sel_s;
          cnt_q   <= '0;
          gnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          a_sr_q   <= {1'b0, a_sr_q[W-1:1]};
          b_sr_q   <= {1'b0, b_sr_q[W-1:1]};
          res_sr_q <= res_sr_d;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            done_q   <= 1'b1;
            res_q    <= res_sr_d;
            res_id_q <= win_q;
            state_q  <= DONE;
          end else begin
            state_q  <= SHIFT;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ptr_q   <= win_q + 2'd1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign res    = res_q;
  assign res_id = res_id_q;

endmodule

// cmosxor: 1-bit XOR cell.
module cmosxor (
  input  logic a,
  input  logic b,
  output logic f53
);
  assign f53 = a ^ b;
endmodule

// File: tb/tb_xor_share_arb.sv
// Self-checking bench for xor_share_arb: directed vector table, hand-written
// multi-cycle sequences, and randomized operations against a reference model.
module tb_xor_share_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           done;
  logic [W-1:0]   res;
  logic [1:0]     res_id;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int m_ptr = 0;
  logic [7:0] last_res = 8'h00;
  int last_id = 0;

  xor_share_arb #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .res    (res),
    .res_id (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] av;
    logic [31:0] bv;
    int          exp_id;
    logic [7:0]  exp_res;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] lane(input logic [31:0] v, input int i);
    return v[i*8 +: 8];
  endfunction

  // Reference arbitration: first set bit at or after ptr, wrapping.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic wait_gnt(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (gnt !== 4'b0000) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // One complete operation: request, grant, drop request, result, idle.
  task automatic run_op(input string nm, input logic [3:0] r, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_id, input logic [7:0] exp_res);
    int n;
    a_in = av;
    b_in = bv;
    req  = r;
    wait_gnt(n);
    chk({nm, "_gnt_seen"}, (n > 0) ? 32'd1 : 32'd0, 32'd1);
    chk({nm, "_gnt"}, 32'(gnt), 32'(4'b0001 << exp_id));
    chk({nm, "_busy_g"}, 32'(busy), 32'd1);
    req = 4'b0000;
    wait_done(n);
    chk({nm, "_lat"}, 32'(n), 32'(W + 1));
    chk({nm, "_res"}, 32'(res), 32'(exp_res));
    chk({nm, "_id"}, 32'(res_id), 32'(exp_id));
    chk({nm, "_busy_d"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({nm, "_done_off"}, 32'(done), 32'd0);
    chk({nm, "_busy_off"}, 32'(busy), 32'd0);
    m_ptr    = (exp_id + 1) % N;
    last_res = exp_res;
    last_id  = exp_id;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_gnt"}, 32'(gnt), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_res"}, 32'(res), 32'd0);
    chk({nm, "_id"}, 32'(res_id), 32'd0);
  endtask

  initial begin
    vec_t vt[6];
    int n;
    int g_prev;
    logic [31:0] av;
    logic [31:0] bv;
    logic [3:0] r;
    int eid;
    int hold_order[5];

    vt[0] = '{4'b0001, 32'h667788A5, 32'h1122333C, 0, 8'h99};
    vt[1] = '{4'b0001, 32'hAAAAAAFF, 32'h555555FF, 0, 8'h00};
    vt[2] = '{4'b0100, 32'h12003456, 32'h34FF789A, 2, 8'hFF};
    vt[3] = '{4'b0101, 32'h00778812, 32'h00334434, 0, 8'h26};
    vt[4] = '{4'b1010, 32'h0000F000, 32'h00000F00, 1, 8'hFF};
    vt[5] = '{4'b1000, 32'h5A000000, 32'h5A123456, 3, 8'h00};
    hold_order = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    req   = 4'b0000;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors; ptr walks 0 -> 1 -> 1 -> 3 -> 1 -> 2 -> 0.
    foreach (vt[i]) begin
      run_op($sformatf("vec%0d", i), vt[i].r, vt[i].av, vt[i].bv, vt[i].exp_id, vt[i].exp_res);
    end

    // All requests held: order 0,1,2,3,0, one grant every W+3 cycles.
    a_in = 32'hA1B2C3D4;
    b_in = 32'h0F1E2D3C;
    req  = 4'b1111;
    g_prev = -1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(n);
      chk($sformatf("hold%0d_gnt", k), 32'(gnt), 32'(4'b0001 << hold_order[k]));
      if (k > 0) chk($sformatf("hold%0d_period", k), 32'(cyc_cnt - g_prev), 32'(W + 3));
      g_prev = cyc_cnt;
      wait_done(n);
      chk($sformatf("hold%0d_id", k), 32'(res_id), 32'(hold_order[k]));
      chk($sformatf("hold%0d_res", k), 32'(res),
          32'(lane(a_in, hold_order[k]) ^ lane(b_in, hold_order[k])));
    end
    req = 4'b0000;
    m_ptr = 1;
    @(negedge clk);

    // Request from requester 1 arrives while requester 0 is being served.
    a_in = 32'h00004C3A;
    b_in = 32'h0000A15F;
    req  = 4'b0001;
    wait_gnt(n);
    chk("busyarr_gnt0", 32'(gnt), 32'd1);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    req = 4'b0010;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      chk("busyarr_no_gnt", 32'(gnt), 32'd0);
    end
    chk("busyarr_done0", 32'(done), 32'd1);
    chk("busyarr_res0", 32'(res), 32'h65);
    chk("busyarr_id0", 32'(res_id), 32'd0);
    wait_gnt(n);
    chk("busyarr_gnt1_delay", 32'(n), 32'd2);
    chk("busyarr_gnt1", 32'(gnt), 32'b0010);
    req = 4'b0000;
    wait_done(n);
    chk("busyarr_res1", 32'(res), 32'hED);
    chk("busyarr_id1", 32'(res_id), 32'd1);
    m_ptr = 2;
    @(negedge clk);

    // Reset during SHIFT with counter at 4: abort, then the same req is re-granted.
    a_in = 32'h00C30000;
    b_in = 32'h003C0000;
    req  = 4'b0100;
    wait_gnt(n);
    chk("rstmid_gnt", 32'(gnt), 32'b0100);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rstmid_now");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rstmid_nodone", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    run_op("rstmid_again", 4'b0100, 32'h00C30000, 32'h003C0000, 2, 8'hFF);

    // Reset in IDLE with ptr=3: next arbitration must start from 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    run_op("rstptr", 4'b1010, 32'h11223344, 32'h55667788, pick(4'b1010, m_ptr), 8'h44);

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      r  = 4'($urandom_range(1, 15));
      av = $urandom;
      bv = $urandom;
      if (k == 0) begin
        av[23:16] = 8'hFF;
        bv[23:16] = 8'hFF;
        r = 4'b0100;
      end
      eid = pick(r, m_ptr);
      run_op($sformatf("rnd%0d", k), r, av, bv, eid, lane(av, eid) ^ lane(bv, eid));
    end

    // req=0 in IDLE: nothing moves, result registers hold.
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_res", 32'(res), 32'(last_res));
      chk("idle_id", 32'(res_id), 32'(last_id));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xor_share_arb.md
XOR_SHARE_ARB -- requirements
Module: xor_share_arb

Interface
REQ-001 Parameter: N, default 4, number of requesters (fixed at 4 in this revision).
REQ-002 Parameter: W, default 8, operand width in bits.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  N  per-requester level request; bit i belongs to requester i.
REQ-006 Port: a_in  input  N*W  operand A; requester i uses bits [i*W +: W].
REQ-007 Port: b_in  input  N*W  operand B; requester i uses bits [i*W +: W].
REQ-008 Port: gnt  output  N  one-hot grant pulse; acknowledges operand capture.
REQ-009 Port: busy  output  1  high from grant cycle through done cycle inclusive.
REQ-010 Port: done  output  1  one-cycle result-valid pulse.
REQ-011 Port: res  output  W  result = A xor B of the served requester; valid when done=1.
REQ-012 Port: res_id  output  2  index of the served requester; valid when done=1.

Function
REQ-013 The block SHALL instantiate exactly one 1-bit cmosxor cell (ports a, b, f53); it is the only XOR resource, and no behavioural XOR SHALL be used for res.
REQ-014 FSM states: IDLE, GRANT, SHIFT, DONE.
REQ-015 IDLE: if req != 0, select the winner by round-robin starting at pointer ptr, then go to GRANT; otherwise stay in IDLE.
REQ-016 GRANT (1 cycle): gnt[winner]=1; load the winner's A and B into shift registers; clear the bit counter; go to SHIFT.
REQ-017 SHIFT (W cycles): feed operand LSBs to the cell each cycle; shift f53 into res_sr at the MSB end (LSB-first serialization); shift A and B right; increment the counter.
REQ-018 After the W-th SHIFT cycle, go to DONE; no early exit.
REQ-019 DONE (1 cycle): done=1, res=res_sr, res_id=winner; ptr=(winner+1) mod N; go to IDLE.
REQ-020 Latency: the grant cycle is followed by W SHIFT cycles, then done; done is asserted exactly W+1 cycles after gnt.
REQ-021 Throughput: one operation per W+3 cycles at most (IDLE, GRANT, W x SHIFT, DONE).
REQ-022 Requesters SHALL hold req and operands until they see gnt; operands are not sampled after GRANT.
REQ-023 Outside GRANT, gnt=0; outside DONE, done=0.
REQ-024 res and res_id hold their last DONE values until the next DONE.
REQ-025 A req that is deasserted before its grant is dropped without trace.
REQ-026 A req asserted while busy=1 is ignored until IDLE and is then arbitrated normally.
REQ-027 A req still high after its own DONE is treated as a new request; ptr rotation prevents it from starving others.
REQ-028 With multiple simultaneous requests, the winner is the first set bit at or after ptr, wrapping from N-1 to 0.
REQ-029 ptr wraps from N-1 to 0.
REQ-030 req=0 in IDLE: stay in IDLE; no outputs change.

Reset
REQ-031 rst_n=0 SHALL immediately force: state=IDLE, ptr=0, counter=0, operand and result shift registers=0, gnt=0, busy=0, done=0, res=0, res_id=0.
REQ-032 Reset asserted mid-operation SHALL abort the operation: no done for the aborted request, and the requester must re-request.
REQ-033 The first arbitration after reset starts at ptr=0.

Verification
REQ-034 Single request: req=0001, A0=8'hA5, B0=8'h3C -> gnt=0001 for 1 cycle; done 9 cycles later; res=8'h99; res_id=0.
REQ-035 All requests held: req=1111 continuously -> grant order 0,1,2,3,0; each done carries the correct res_id and xor.
REQ-036 Wrap: ptr=3 (after serving 2), req=0101 -> requester 0 served, not 2; then ptr=1.
REQ-037 Busy arrival: req[1] raised during SHIFT for requester 0 -> no gnt until IDLE; gnt=0010 on the following GRANT.
REQ-038 Reset mid-SHIFT: rst_n=0 at counter=4 -> all outputs 0 immediately; no done; after release, the same req is granted afresh.
REQ-039 Edge operands: A=8'hFF, B=8'hFF -> res=8'h00; A=8'h00, B=8'hFF -> res=8'hFF.
